// File: rtl/gc_engine_pkg.sv
// Shared types and widths for the GC engine slice.
// GC_WEAR_LEVEL_EN (optional) enables per-block erase counters in gc_engine.
package gc_engine_pkg;

   localparam int GC_BLK_W       = 4;
   localparam int GC_ERASE_CNT_W = 16;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      SCAN,
      MOVE,
      PARK,
      ERASE,
      DONE
   } gc_state_t;

endpackage

// File: rtl/gc_engine_if.sv
// Controller / remap-table handshake bundle for gc_engine.
// slave = engine side, master = controller/remap side.
interface gc_engine_if import gc_engine_pkg::*; #(
   parameter int BLK_W = GC_BLK_W
);
   logic             gc_ini;
   logic             invalid_flag;
   logic [BLK_W-1:0] invalid_blk;
   logic             alloc_req;
   logic             alloc_ack;
   logic [BLK_W-1:0] alloc_blk;
   logic             gc_request;
   logic             gc_start;
   logic             active_request;
   logic             gc_interrupt;
   logic             move_flag;
   logic             move_done_flag;
   logic             erase_flag;
   logic             erase_done;
   logic [BLK_W-1:0] erase_blk;
   logic             request_done;
   logic             gc_fail;

   modport slave (
      input  gc_ini, invalid_flag, invalid_blk, alloc_req, gc_start, active_request,
             move_done_flag, erase_done,
      output alloc_ack, alloc_blk, gc_request, gc_interrupt, move_flag, erase_flag,
             erase_blk, request_done, gc_fail
   );

   modport master (
      output gc_ini, invalid_flag, invalid_blk, alloc_req, gc_start, active_request,
             move_done_flag, erase_done,
      input  alloc_ack, alloc_blk, gc_request, gc_interrupt, move_flag, erase_flag,
             erase_blk, request_done, gc_fail
   );
endinterface

// File: rtl/gc_free_fifo.sv
// Free-block pool: circular FIFO with synchronous clear and occupancy count.
module gc_free_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 4
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

   always_ff @(posedge CLK) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/gc_engine.sv
// GC engine: free-block pool, invalid-page counters, victim scan and move/erase sequencing.
// Build option GC_WEAR_LEVEL_EN: erase counters break invalid-count ties in the scan.
module gc_engine import gc_engine_pkg::*; #(
   parameter int NUM_BLK       = 16,
   parameter int PAGES_PER_BLK = 32,
   parameter int FREE_LOW      = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   gc_engine_if.slave  bus
);
   localparam int BLK_W = $clog2(NUM_BLK);
   localparam int CNT_W = $clog2(PAGES_PER_BLK+1);
   localparam int FC_W  = $clog2(NUM_BLK+1);

   gc_state_t                      state;
   logic [NUM_BLK-1:0][CNT_W-1:0]  cnt;
   logic [NUM_BLK-1:0]             in_use;
   logic [BLK_W-1:0]               last_alloc, scan_idx, init_idx;
   logic [BLK_W-1:0]               best_blk, nxt_best_blk;
   logic [CNT_W-1:0]               best_cnt, nxt_best_cnt;
   logic                           inited;
   logic                           pool_push, pool_pop, pool_empty, erase_fin;
   logic [BLK_W-1:0]               pool_head, push_blk;
   logic [FC_W-1:0]                free_cnt;
   logic                           cand;

   // Alloc is refused while the pool is being rebuilt or cleared.
   assign pool_pop      = bus.alloc_req && !pool_empty && (state != INIT) && !bus.gc_ini;
   assign bus.alloc_ack = pool_pop;
   assign bus.alloc_blk = pool_head;

   assign erase_fin = (state == ERASE) && bus.erase_flag && bus.erase_done;
   assign pool_push = (state == INIT) || erase_fin;
   assign push_blk  = (state == INIT) ? init_idx : bus.erase_blk;

   gc_free_fifo #(.DEPTH(NUM_BLK), .WIDTH(BLK_W)) u_pool (
      .CLK       (CLK),
      .nRST      (nRST),
      .clear     (bus.gc_ini),
      .push      (pool_push),
      .push_data (push_blk),
      .pop       (pool_pop),
      .head      (pool_head),
      .empty     (pool_empty),
      .count     (free_cnt)
   );

`ifdef GC_WEAR_LEVEL_EN
   logic [NUM_BLK-1:0][GC_ERASE_CNT_W-1:0] ecnt;
   logic [GC_ERASE_CNT_W-1:0]              best_ec, nxt_best_ec;
`endif

   for (genvar b = 0; b < NUM_BLK; b++) begin : g_blk
      logic [CNT_W-1:0] cnt_q;
      logic             in_use_q;
      logic             is_inv, is_erased;

      assign is_inv    = bus.invalid_flag && (bus.invalid_blk == BLK_W'(b));
      assign is_erased = erase_fin && (bus.erase_blk == BLK_W'(b));
      assign cnt[b]    = cnt_q;
      assign in_use[b] = in_use_q;

      // A same-cycle invalidate on the erased block loses to the clear.
      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            cnt_q    <= '0;
            in_use_q <= 1'b0;
         end else if (bus.gc_ini) begin
            cnt_q    <= '0;
            in_use_q <= 1'b0;
         end else begin
            if (is_erased)
               cnt_q <= '0;
            else if (is_inv && cnt_q != CNT_W'(PAGES_PER_BLK))
               cnt_q <= cnt_q + 1'b1;
            if (pool_pop && pool_head == BLK_W'(b))
               in_use_q <= 1'b1;
            else if (is_erased)
               in_use_q <= 1'b0;
         end
      end

`ifdef GC_WEAR_LEVEL_EN
      logic [GC_ERASE_CNT_W-1:0] ec_q;
      assign ecnt[b] = ec_q;
      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST)                   ec_q <= '0;
         else if (bus.gc_ini)         ec_q <= '0;
         else if (is_erased && ec_q != '1) ec_q <= ec_q + 1'b1;
      end
`endif
   end

   // Scan step: the freshly allocated block is still being filled, so skip it.
   assign cand = in_use[scan_idx] && (scan_idx != last_alloc);

   always_comb begin
      nxt_best_cnt = best_cnt;
      nxt_best_blk = best_blk;
`ifdef GC_WEAR_LEVEL_EN
      nxt_best_ec  = best_ec;
      if (cand && ((cnt[scan_idx] > best_cnt) ||
                   (cnt[scan_idx] == best_cnt && best_cnt != '0 && ecnt[scan_idx] < best_ec))) begin
         nxt_best_cnt = cnt[scan_idx];
         nxt_best_blk = scan_idx;
         nxt_best_ec  = ecnt[scan_idx];
      end
`else
      if (cand && (cnt[scan_idx] > best_cnt)) begin
         nxt_best_cnt = cnt[scan_idx];
         nxt_best_blk = scan_idx;
      end
`endif
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state            <= IDLE;
         inited           <= 1'b0;
         init_idx         <= '0;
         scan_idx         <= '0;
         best_cnt         <= '0;
         best_blk         <= '0;
         last_alloc       <= '0;
         bus.gc_request   <= 1'b0;
         bus.gc_interrupt <= 1'b0;
         bus.move_flag    <= 1'b0;
         bus.erase_flag   <= 1'b0;
         bus.erase_blk    <= '0;
         bus.request_done <= 1'b0;
         bus.gc_fail      <= 1'b0;
`ifdef GC_WEAR_LEVEL_EN
         best_ec          <= '0;
`endif
      end else if (bus.gc_ini) begin
         state            <= INIT;
         inited           <= 1'b0;
         init_idx         <= '0;
         last_alloc       <= '0;
         bus.gc_request   <= 1'b0;
         bus.gc_interrupt <= 1'b0;
         bus.move_flag    <= 1'b0;
         bus.erase_flag   <= 1'b0;
         bus.request_done <= 1'b0;
         bus.gc_fail      <= 1'b0;
      end else begin
         if (pool_pop) last_alloc <= pool_head;
         bus.gc_request   <= (state == IDLE) && inited && (free_cnt < FC_W'(FREE_LOW));
         bus.gc_fail      <= 1'b0;
         bus.request_done <= 1'b0;
         case (state)
            INIT: begin
               init_idx <= init_idx + 1'b1;
               if (init_idx == BLK_W'(NUM_BLK-1)) begin
                  state  <= IDLE;
                  inited <= 1'b1;
               end
            end
            IDLE: if (bus.gc_start) begin
               state    <= SCAN;
               scan_idx <= '0;
               best_cnt <= '0;
               best_blk <= '0;
`ifdef GC_WEAR_LEVEL_EN
               best_ec  <= '1;
`endif
            end
            SCAN: begin
               best_cnt <= nxt_best_cnt;
               best_blk <= nxt_best_blk;
`ifdef GC_WEAR_LEVEL_EN
               best_ec  <= nxt_best_ec;
`endif
               scan_idx <= scan_idx + 1'b1;
               if (scan_idx == BLK_W'(NUM_BLK-1)) begin
                  if (nxt_best_cnt == '0) begin
                     bus.gc_fail <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     bus.erase_blk <= nxt_best_blk;
                     state         <= MOVE;
                  end
               end
            end
            MOVE: begin
               if (!bus.move_flag)
                  bus.move_flag <= 1'b1;
               else if (bus.move_done_flag) begin
                  bus.move_flag <= 1'b0;
                  if (bus.active_request) begin
                     bus.gc_interrupt <= 1'b1;
                     state            <= PARK;
                  end else
                     state <= ERASE;
               end
            end
            PARK: if (!bus.active_request) begin
               bus.gc_interrupt <= 1'b0;
               state            <= ERASE;
            end
            ERASE: begin
               if (!bus.erase_flag)
                  bus.erase_flag <= 1'b1;
               else if (bus.erase_done) begin
                  bus.erase_flag   <= 1'b0;
                  bus.request_done <= 1'b1;
                  state            <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gc_engine.sv
// Directed bench for gc_engine: alloc table plus hand-written GC sequences.
module tb_gc_engine;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   gc_engine_if #(.BLK_W(4)) bus ();

   gc_engine #(.NUM_BLK(16), .PAGES_PER_BLK(32), .FREE_LOW(2)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       alloc;
      logic       exp_ack;
      logic [3:0] exp_blk;
      logic [4:0] exp_free;
      logic       exp_req;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic invalidate(input logic [3:0] blk, input int n);
      for (int k = 0; k < n; k++) begin
         bus.invalid_flag = 1'b1;
         bus.invalid_blk  = blk;
         step();
      end
      bus.invalid_flag = 1'b0;
   endtask

   // The pool must never see a net push while already full.
   always @(negedge CLK) begin
      if (nRST && dut.pool_push && !dut.pool_pop && dut.free_cnt == 5'd16) begin
         n_err++;
         $display("FAIL pool_push_full: push with free_cnt %0d required < 16", dut.free_cnt);
      end
   end

   initial begin
      logic [3:0] exp_wear_blk;
      for (int i = 0; i < 15; i++)
         tbl[i] = '{alloc: 1'b1, exp_ack: 1'b1, exp_blk: 4'(i), exp_free: 5'(15 - i), exp_req: 1'b0};
      tbl[15] = '{alloc: 1'b0, exp_ack: 1'b0, exp_blk: 4'd0, exp_free: 5'd1, exp_req: 1'b1};

      bus.gc_ini = 0; bus.invalid_flag = 0; bus.invalid_blk = 0; bus.alloc_req = 0;
      bus.gc_start = 0; bus.active_request = 0; bus.move_done_flag = 0; bus.erase_done = 0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_gc_request", bus.gc_request, 0);
      chk("rst_move_flag", bus.move_flag, 0);
      chk("rst_erase_flag", bus.erase_flag, 0);
      chk("rst_request_done", bus.request_done, 0);
      chk("rst_free_cnt", dut.free_cnt, 0);
      nRST = 1'b1;
      step(); step();
      chk("pre_ini_gc_request", bus.gc_request, 0);
      bus.alloc_req = 1'b1; #1;
      chk("pre_ini_alloc_ack", bus.alloc_ack, 0);
      bus.alloc_req = 1'b0;

      // Pool rebuild
      bus.gc_ini = 1'b1; step(); bus.gc_ini = 1'b0;
      bus.alloc_req = 1'b1; #1;
      chk("init_alloc_ack", bus.alloc_ack, 0);
      bus.alloc_req = 1'b0;
      repeat (15) step();
      chk("init_free_15", dut.free_cnt, 15);
      step();
      chk("init_free_16", dut.free_cnt, 16);

      // Alloc table
      for (int i = 0; i < 16; i++) begin
         bus.alloc_req = tbl[i].alloc; #1;
         chk($sformatf("tbl%0d_ack", i), bus.alloc_ack, tbl[i].exp_ack);
         if (tbl[i].exp_ack) chk($sformatf("tbl%0d_blk", i), bus.alloc_blk, tbl[i].exp_blk);
         step();
         bus.alloc_req = 1'b0;
         chk($sformatf("tbl%0d_free", i), dut.free_cnt, tbl[i].exp_free);
         chk($sformatf("tbl%0d_req", i), bus.gc_request, tbl[i].exp_req);
      end

      // All counts zero: scan fails
      bus.gc_start = 1'b1; step(); bus.gc_start = 1'b0;
      repeat (15) step();
      chk("fail_not_yet", bus.gc_fail, 0);
      chk("scan_req_low", bus.gc_request, 0);
      step();
      chk("gc_fail_pulse", bus.gc_fail, 1);
      chk("fail_no_move", bus.move_flag, 0);
      step();
      chk("gc_fail_clear", bus.gc_fail, 0);
      chk("fail_idle_req", bus.gc_request, 1);

      // Tie on count -> lower index; erase with simultaneous alloc and invalidate
      invalidate(4'd3, 5);
      invalidate(4'd7, 5);
      chk("cnt3_5", dut.cnt[3], 5);
      chk("cnt7_5", dut.cnt[7], 5);
      bus.gc_start = 1'b1; step(); bus.gc_start = 1'b0;
      repeat (16) step();
      chk("move_flag_16", bus.move_flag, 0);
      chk("victim_3", bus.erase_blk, 3);
      step();
      chk("move_flag_17", bus.move_flag, 1);
      bus.move_done_flag = 1'b1; step(); bus.move_done_flag = 1'b0;
      chk("move_flag_fall", bus.move_flag, 0);
      chk("erase_flag_entry", bus.erase_flag, 0);
      chk("no_park", bus.gc_interrupt, 0);
      step();
      chk("erase_flag_rise", bus.erase_flag, 1);
      bus.erase_done = 1'b1; bus.alloc_req = 1'b1;
      bus.invalid_flag = 1'b1; bus.invalid_blk = 4'd3; #1;
      chk("swap_ack", bus.alloc_ack, 1);
      chk("swap_blk", bus.alloc_blk, 15);
      step();
      bus.erase_done = 1'b0; bus.alloc_req = 1'b0; bus.invalid_flag = 1'b0;
      chk("swap_free", dut.free_cnt, 1);
      chk("cnt3_cleared", dut.cnt[3], 0);
      chk("request_done", bus.request_done, 1);
      chk("erase_flag_fall", bus.erase_flag, 0);
      step();
      chk("request_done_pulse", bus.request_done, 0);

      // Park for host traffic
      invalidate(4'd5, 6);
      bus.gc_start = 1'b1; step(); bus.gc_start = 1'b0;
      repeat (17) step();
      chk("park_move_flag", bus.move_flag, 1);
      chk("victim_5", bus.erase_blk, 5);
      bus.active_request = 1'b1; bus.move_done_flag = 1'b1; step(); bus.move_done_flag = 1'b0;
      chk("park_interrupt", bus.gc_interrupt, 1);
      chk("park_erase_low", bus.erase_flag, 0);
      bus.gc_start = 1'b1; step(); bus.gc_start = 1'b0;
      chk("park_hold", bus.gc_interrupt, 1);
      chk("park_hold_erase", bus.erase_flag, 0);
      bus.active_request = 1'b0; step();
      chk("unpark_interrupt", bus.gc_interrupt, 0);
      step();
      chk("erase_after_park", bus.erase_flag, 1);
      bus.erase_done = 1'b1; step(); bus.erase_done = 1'b0;
      chk("park_request_done", bus.request_done, 1);
      chk("park_free", dut.free_cnt, 2);
      step();

      // Pushed blocks come out in order; empty-pool alloc refused
      bus.alloc_req = 1'b1; #1;
      chk("tail_blk_3", bus.alloc_blk, 3);
      step(); #1;
      chk("tail_blk_5", bus.alloc_blk, 5);
      step(); #1;
      chk("empty_pool_ack", bus.alloc_ack, 0);
      bus.alloc_req = 1'b0;
      step();
      chk("empty_free", dut.free_cnt, 0);

      // Tie 3 vs 7; block 3 has one prior erase
`ifdef GC_WEAR_LEVEL_EN
      exp_wear_blk = 4'd7;
`else
      exp_wear_blk = 4'd3;
`endif
      invalidate(4'd3, 5);
      bus.gc_start = 1'b1; step(); bus.gc_start = 1'b0;
      repeat (17) step();
      chk("tie_move_flag", bus.move_flag, 1);
      chk("tie_victim", bus.erase_blk, exp_wear_blk);

      // Async reset mid-GC
      nRST = 1'b0; #1;
      chk("abort_move_flag", bus.move_flag, 0);
      chk("abort_pool_empty", dut.free_cnt, 0);
      chk("abort_erase_blk", bus.erase_blk, 0);
      nRST = 1'b1;
      step();

      // Counter saturation
      invalidate(4'd2, 34);
      chk("cnt2_saturate", dut.cnt[2], 32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
